reg_scoreboard: RTL and testbench

//  Writer-side companion of the stall logic: records every destination register issued from ID

---
 rtl/mips_pkg.sv | 18 +
 rtl/sb_entry.sv | 70 +++++++
 rtl/reg_scoreboard.sv | 139 +++++++++++++
 tb/tb_reg_scoreboard.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline constants for the MIPS core.
// Holds the architectural register file geometry and the in-flight depth
// from which the scoreboard counter widths are derived.
package mips_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int NUM_ARCH_REGS = 32;
  localparam logic [REG_ADDR_W-1:0] R0 = 5'd0;

  // Writes can be outstanding in EXE, MEM and WB at the same time.
  localparam int MAX_INFLIGHT = 3;

  // Per-register counter must reach MAX_INFLIGHT; the total counter gets one
  // extra bit of headroom so that overflow is still reported as an error.
  localparam int SB_CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int SB_TOT_W = SB_CNT_W + 1;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: saturating up/down count of writes in flight to a
// single architectural register.
// Ports:
//   clk, rst       clock and synchronous active-low reset
//   inc, dec       issue / retire event targeting this register
//   count          current in-flight count (registered)
//   busy           count != 0
//   retiring_last  the retire this cycle brings the count back to zero
//   err            one-cycle pulse on overflow (inc at max) or underflow (dec at 0)
module sb_entry
  import mips_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             retiring_last,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             err_d;

  // Next count: simultaneous inc and dec cancel; out-of-range steps hold and flag.
  always_comb begin
    count_d = count_q;
    err_d   = 1'b0;
    case ({inc, dec})
      2'b10: begin
        if (count_q == CNT_MAX) begin
          err_d = 1'b1;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      2'b01: begin
        if (count_q == CNT_ZERO) begin
          err_d = 1'b1;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end
      default: count_d = count_q;
    endcase
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= CNT_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign count         = count_q;
  assign busy          = (count_q != CNT_ZERO);
  assign retiring_last = dec & (count_q == CNT_ONE);
  assign err           = err_d;

endmodule

// File: rtl/reg_scoreboard.sv
// Register busy table beside the ID/EXE pipeline register.
// Counts writes issued from ID into EXE per destination register and
// releases them when they retire in WB; the ID stage queries its sources
// against this table and stalls on hazard_detected.
// Ports:
//   clk, rst                       clock and synchronous active-low reset
//   issue_valid/wb_en/dest, flush  instruction leaving ID this cycle
//   retire_valid, retire_dest      register write in WB this cycle
//   src1, src2, is_single_src, is_BNE   ID-stage source query
//   hazard_detected                combinational stall request
//   busy_vec                       per-register busy bitmap (from registered counts)
//   inflight                       registered total of outstanding writes
//   sb_err                         sticky overflow/underflow flag
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int NUM_REGS = NUM_ARCH_REGS,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int CNT_W    = SB_CNT_W,
  parameter int TOT_W    = SB_TOT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_wb_en,
  input  logic [ADDR_W-1:0]   issue_dest,
  input  logic                flush,
  input  logic                retire_valid,
  input  logic [ADDR_W-1:0]   retire_dest,
  input  logic [ADDR_W-1:0]   src1,
  input  logic [ADDR_W-1:0]   src2,
  input  logic                is_single_src,
  input  logic                is_BNE,
  output logic                hazard_detected,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [TOT_W-1:0]    inflight,
  output logic                sb_err
);

  localparam logic [TOT_W-1:0] TOT_ZERO = {TOT_W{1'b0}};
  localparam logic [TOT_W-1:0] TOT_ONE  = TOT_W'(1);
  localparam logic [TOT_W-1:0] TOT_MAX  = {TOT_W{1'b1}};

  logic                use2_s;
  logic                inc_s;
  logic                dec_s;
  logic [NUM_REGS-1:1] inc_vec_s;
  logic [NUM_REGS-1:1] dec_vec_s;
  logic [NUM_REGS-1:1] busy_s;
  logic [NUM_REGS-1:1] last_s;
  logic [NUM_REGS-1:1] err_s;
  logic [NUM_REGS-1:0] busy_eff_s;
  logic [CNT_W-1:0]    count_s [1:NUM_REGS-1];

  logic [TOT_W-1:0]    tot_q;
  logic [TOT_W-1:0]    tot_d;
  logic                tot_err_s;
  logic                sb_err_q;
  logic                sb_err_d;

  // A stalled or flushed instruction must never enter the table.
  assign inc_s = issue_valid & issue_wb_en & (issue_dest != R0) & ~flush & ~hazard_detected;
  assign dec_s = retire_valid & (retire_dest != R0);

  // R0 has no entry: it is hard-wired and never busy.
  assign busy_eff_s[0] = 1'b0;
  assign busy_vec[0]   = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    assign inc_vec_s[i] = inc_s & (issue_dest == ADDR_W'(i));
    assign dec_vec_s[i] = dec_s & (retire_dest == ADDR_W'(i));

    sb_entry #(
      .CNT_W (CNT_W)
    ) u_entry (
      .clk           (clk),
      .rst           (rst),
      .inc           (inc_vec_s[i]),
      .dec           (dec_vec_s[i]),
      .count         (count_s[i]),
      .busy          (busy_s[i]),
      .retiring_last (last_s[i]),
      .err           (err_s[i])
    );

    // WB writes through the register file, so the last retiring write is already visible.
    assign busy_eff_s[i] = busy_s[i] & ~last_s[i];
    assign busy_vec[i]   = (count_s[i] != {CNT_W{1'b0}});
  end

  // Source query; a branch compare always reads both operands.
  always_comb begin
    use2_s          = is_BNE | ~is_single_src;
    hazard_detected = busy_eff_s[src1] | (use2_s & busy_eff_s[src2]);
  end

  // Total in-flight count, saturating with the same hold/flag rules as an entry.
  always_comb begin
    tot_d     = tot_q;
    tot_err_s = 1'b0;
    case ({inc_s, dec_s})
      2'b10: begin
        if (tot_q == TOT_MAX) begin
          tot_err_s = 1'b1;
        end else begin
          tot_d = tot_q + TOT_ONE;
        end
      end
      2'b01: begin
        if (tot_q == TOT_ZERO) begin
          tot_err_s = 1'b1;
        end else begin
          tot_d = tot_q - TOT_ONE;
        end
      end
      default: tot_d = tot_q;
    endcase
  end

  // Error flag is sticky until reset.
  always_comb begin
    sb_err_d = sb_err_q | tot_err_s | (|err_s);
  end

  // Total counter and error flag registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tot_q    <= TOT_ZERO;
      sb_err_q <= 1'b0;
    end else begin
      tot_q    <= tot_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign inflight = tot_q;
  assign sb_err   = sb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_wb_en;
  logic [4:0]  issue_dest;
  logic        flush;
  logic        retire_valid;
  logic [4:0]  retire_dest;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic        is_single_src;
  logic        is_BNE;
  logic        hazard_detected;
  logic [31:0] busy_vec;
  logic [2:0]  inflight;
  logic        sb_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid     (issue_valid),
    .issue_wb_en     (issue_wb_en),
    .issue_dest      (issue_dest),
    .flush           (flush),
    .retire_valid    (retire_valid),
    .retire_dest     (retire_dest),
    .src1            (src1),
    .src2            (src2),
    .is_single_src   (is_single_src),
    .is_BNE          (is_BNE),
    .hazard_detected (hazard_detected),
    .busy_vec        (busy_vec),
    .inflight        (inflight),
    .sb_err          (sb_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 5'd5;
    tick; tick;
    issue_valid = 1'b0; issue_wb_en = 1'b0; issue_dest = 5'd0;
    src1 = 5'd5; is_single_src = 1'b1;
    #1;
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h expected %h", busy_vec, 32'h0); end
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight: got %0d expected 0", inflight); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", sb_err); end
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b expected 0", hazard_detected); end
    rst = 1'b1; src1 = 5'd0;
    tick;
  endtask

  task automatic test_issue;
    issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 5'd5;
    tick;
    issue_valid = 1'b0; src1 = 5'd5; is_single_src = 1'b1;
    #1;
    checks++; if (hazard_detected !== 1'b1) begin errors++; $display("FAIL issue_hazard: got %b expected 1", hazard_detected); end
    checks++; if (busy_vec !== 32'h0000_0020) begin errors++; $display("FAIL issue_busy: got %h expected %h", busy_vec, 32'h20); end
    checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL issue_inflight: got %0d expected 1", inflight); end
    src1 = 5'd6; #1;
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL issue_other_src: got %b expected 0", hazard_detected); end
    src1 = 5'd0; retire_valid = 1'b1; retire_dest = 5'd5;
    tick;
    retire_valid = 1'b0;
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL issue_retired_busy: got %h expected 0", busy_vec); end
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL issue_retired_inflight: got %0d expected 0", inflight); end
  endtask

  task automatic test_r0;
    issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 5'd0; src1 = 5'd0;
    tick;
    issue_valid = 1'b0;
    #1;
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL r0_hazard: got %b expected 0", hazard_detected); end
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL r0_busy: got %h expected 0", busy_vec); end
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL r0_inflight: got %0d expected 0", inflight); end
  endtask

  task automatic test_multi;
    src1 = 5'd0; src2 = 5'd0; is_single_src = 1'b1; is_BNE = 1'b0;
    issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 5'd7;
    tick; tick;
    issue_valid = 1'b0;
    checks++; if (busy_vec !== 32'h0000_0080) begin errors++; $display("FAIL multi_busy2: got %h expected %h", busy_vec, 32'h80); end
    checks++; if (inflight !== 3'd2) begin errors++; $display("FAIL multi_inflight2: got %0d expected 2", inflight); end
    retire_valid = 1'b1; retire_dest = 5'd7;
    tick;
    retire_valid = 1'b0;
    checks++; if (busy_vec !== 32'h0000_0080) begin errors++; $display("FAIL multi_busy1: got %h expected %h", busy_vec, 32'h80); end
    checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL multi_inflight1: got %0d expected 1", inflight); end
    src2 = 5'd7; is_BNE = 1'b1; #1;
    checks++; if (hazard_detected !== 1'b1) begin errors++; $display("FAIL multi_bne_busy: got %b expected 1", hazard_detected); end
    retire_valid = 1'b1; retire_dest = 5'd7; #1;
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL multi_bne_retiring: got %b expected 0", hazard_detected); end
    tick;
    retire_valid = 1'b0;
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL multi_busy0: got %h expected 0", busy_vec); end
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL multi_inflight0: got %0d expected 0", inflight); end
    src2 = 5'd0; is_BNE = 1'b0;
  endtask

  task automatic test_same_cycle;
    src1 = 5'd0; is_single_src = 1'b1;
    issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 5'd9;
    tick;
    retire_valid = 1'b1; retire_dest = 5'd9;
    tick;
    retire_valid = 1'b0; issue_valid = 1'b0;
    checks++; if (busy_vec !== 32'h0000_0200) begin errors++; $display("FAIL same_busy: got %h expected %h", busy_vec, 32'h200); end
    checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL same_inflight: got %0d expected 1", inflight); end
    issue_valid = 1'b1; issue_dest = 5'd3;
    tick;
    issue_dest = 5'd9; src1 = 5'd3; #1;
    checks++; if (hazard_detected !== 1'b1) begin errors++; $display("FAIL stall_hazard: got %b expected 1", hazard_detected); end
    tick;
    issue_valid = 1'b0; src1 = 5'd0;
    checks++; if (busy_vec !== 32'h0000_0208) begin errors++; $display("FAIL stall_busy: got %h expected %h", busy_vec, 32'h208); end
    checks++; if (inflight !== 3'd2) begin errors++; $display("FAIL stall_inflight: got %0d expected 2", inflight); end
    retire_valid = 1'b1; retire_dest = 5'd9;
    tick;
    checks++; if (busy_vec !== 32'h0000_0008) begin errors++; $display("FAIL stall_count9: got %h expected %h", busy_vec, 32'h8); end
    retire_dest = 5'd3;
    tick;
    retire_valid = 1'b0;
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL same_drain: got %0d expected 0", inflight); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL same_err: got %b expected 0", sb_err); end
  endtask

  task automatic test_errors;
    retire_valid = 1'b1; retire_dest = 5'd12;
    tick;
    retire_valid = 1'b0;
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL underflow_err: got %b expected 1", sb_err); end
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL underflow_inflight: got %0d expected 0", inflight); end
    tick;
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", sb_err); end
    src1 = 5'd0; is_single_src = 1'b1;
    issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 5'd4;
    tick; tick; tick;
    checks++; if (inflight !== 3'd3) begin errors++; $display("FAIL fill_inflight: got %0d expected 3", inflight); end
    tick;
    issue_valid = 1'b0;
    checks++; if (busy_vec !== 32'h0000_0010) begin errors++; $display("FAIL overflow_busy: got %h expected %h", busy_vec, 32'h10); end
    checks++; if (inflight !== 3'd4) begin errors++; $display("FAIL overflow_inflight: got %0d expected 4", inflight); end
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL overflow_err: got %b expected 1", sb_err); end
    retire_valid = 1'b1; retire_dest = 5'd4;
    tick; tick;
    checks++; if (busy_vec !== 32'h0000_0010) begin errors++; $display("FAIL hold_busy: got %h expected %h", busy_vec, 32'h10); end
    tick;
    retire_valid = 1'b0;
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL hold_drained: got %h expected 0", busy_vec); end
    checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL hold_inflight: got %0d expected 1", inflight); end
    rst = 1'b0;
    tick;
    rst = 1'b1; src1 = 5'd4; #1;
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL rst2_busy: got %h expected 0", busy_vec); end
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL rst2_inflight: got %0d expected 0", inflight); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL rst2_err: got %b expected 0", sb_err); end
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL rst2_hazard: got %b expected 0", hazard_detected); end
  endtask

  initial begin
    rst = 1'b0; issue_valid = 1'b0; issue_wb_en = 1'b0; issue_dest = 5'd0;
    flush = 1'b0; retire_valid = 1'b0; retire_dest = 5'd0;
    src1 = 5'd0; src2 = 5'd0; is_single_src = 1'b0; is_BNE = 1'b0;
    test_reset;
    test_issue;
    test_r0;
    test_multi;
    test_same_cycle;
    test_errors;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
